// File: rtl/sm_clk_ctrl.sv
// ---------------------------------------------------------------------------
// sm_clk_ctrl -- run-control sequencer for the schoolMIPS core clock.
//
// Produces a single-cycle clock-enable pulse (cpuEn) that advances the core.
// Four run modes are selected by the board switches: halt, free-run at a
// programmable divided rate, single-step from a debounced button, and a burst
// of burstLen steps per button press.
//
// Ports:
//   clk       in   board clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   mode      in   [1:0] 00 halt, 01 run, 10 single-step, 11 burst (pre-synced)
//   devide    in   [3:0] rate select; run period = 2^(SHIFT+devide) cycles
//   stepBtn   in   raw asynchronous step button
//   burstLen  in   [7:0] steps per burst, 0 disables bursts
//   cpuEn     out  one-cycle core advance pulse (registered)
//   busy      out  high while in RUN or BURST
//   state     out  [2:0] FSM state (HALT=0 RUN=1 STEP=2 ARMED=3 BURST=4)
//   stepCnt   out  [31:0] number of cpuEn pulses issued since reset (wraps)
// ---------------------------------------------------------------------------
module sm_clk_ctrl #(
    parameter int SHIFT      = 16,
    parameter int DIV_W      = 32,
    parameter int DEB_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [3:0]  devide,
    input  logic        stepBtn,
    input  logic [7:0]  burstLen,
    output logic        cpuEn,
    output logic        busy,
    output logic [2:0]  state,
    output logic [31:0] stepCnt
);

    typedef enum logic [2:0] {
        HALT  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        ARMED = 3'd3,
        BURST = 3'd4
    } state_t;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    // Counter value on which the DEB_CYCLES-th consecutive differing cycle lands.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button path: 2-flop synchroniser, debouncer, rising-edge pulse
    // ------------------------------------------------------------------
    logic             sync1Reg;
    logic             sync2Reg;
    logic             debLevelReg;
    logic [DEB_W-1:0] debCntReg;
    logic             riseReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1Reg    <= 1'b0;
            sync2Reg    <= 1'b0;
            debLevelReg <= 1'b0;
            debCntReg   <= '0;
            riseReg     <= 1'b0;
        end else begin
            sync1Reg <= stepBtn;
            sync2Reg <= sync1Reg;
            riseReg  <= 1'b0;
            if (sync2Reg == debLevelReg) begin
                debCntReg <= '0;
            end else if (debCntReg == DEB_LAST) begin
                // New level has been stable long enough: accept it.
                debLevelReg <= sync2Reg;
                debCntReg   <= '0;
                riseReg     <= sync2Reg;
            end else begin
                debCntReg <= debCntReg + DEB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler terminal-count mask: low (SHIFT+devide) bits set
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] periodMask;

    genvar gi;
    generate
        for (gi = 0; gi < DIV_W; gi++) begin : g_mask
            assign periodMask[gi] = (gi < (SHIFT + int'(devide)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State, prescaler, burst counter, pulse and step counter
    // ------------------------------------------------------------------
    state_t           stateReg,   stateNext;
    logic [DIV_W-1:0] preReg,     preNext;
    logic [7:0]       remReg,     remNext;
    logic             cpuEnReg,   cpuEnNext;
    logic [31:0]      stepCntReg, stepCntNext;
    logic [1:0]       modeReg;
    logic [3:0]       devideReg;

    logic modeChg;
    logic devChg;
    logic runLike;
    logic atMax;
    logic tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= HALT;
            preReg     <= '0;
            remReg     <= '0;
            cpuEnReg   <= 1'b0;
            stepCntReg <= '0;
            modeReg    <= 2'b00;
            devideReg  <= 4'd0;
        end else begin
            stateReg   <= stateNext;
            preReg     <= preNext;
            remReg     <= remNext;
            cpuEnReg   <= cpuEnNext;
            stepCntReg <= stepCntNext;
            modeReg    <= mode;
            devideReg  <= devide;
        end
    end

    always_comb begin
        stateNext = stateReg;
        remNext   = remReg;
        preNext   = '0;
        cpuEnNext = 1'b0;

        modeChg = (mode != modeReg);
        devChg  = (devide != devideReg);
        runLike = (stateReg == RUN) || (stateReg == BURST);
        atMax   = (preReg == periodMask);
        // A mode or rate change restarts the period instead of firing.
        tc      = runLike && atMax && !modeChg && !devChg;

        if (runLike && !modeChg && !devChg && !atMax) begin
            preNext = preReg + DIV_W'(1);
        end

        case (stateReg)
            RUN: begin
                cpuEnNext = tc;
            end
            STEP: begin
                cpuEnNext = riseReg && !modeChg;
            end
            ARMED: begin
                if (riseReg && (burstLen != 8'd0)) begin
                    stateNext = BURST;
                    remNext   = burstLen;
                end
            end
            BURST: begin
                if (tc) begin
                    cpuEnNext = 1'b1;
                    remNext   = remReg - 8'd1;
                    if (remReg == 8'd1) begin
                        stateNext = ARMED;
                    end
                end
            end
            default: begin
            end
        endcase

        // Switch decode has the final word over the per-state logic.
        case (mode)
            2'b00:   stateNext = HALT;
            2'b01:   stateNext = RUN;
            2'b10:   stateNext = STEP;
            default: begin
                if (stateReg != ARMED && stateReg != BURST) begin
                    stateNext = ARMED;
                end
            end
        endcase

        // Leaving the burst pair abandons any steps still owed.
        if (stateNext != ARMED && stateNext != BURST) begin
            remNext = '0;
        end

        stepCntNext = stepCntReg + 32'(cpuEnNext);
    end

    assign cpuEn   = cpuEnReg;
    assign busy    = (stateReg == RUN) || (stateReg == BURST);
    assign state   = stateReg;
    assign stepCnt = stepCntReg;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sm_clk_ctrl -- scoreboard bench for sm_clk_ctrl (SHIFT=0, DEB_CYCLES=4).
// Stimulus pushes the expected pulse records (state, stepCnt, spacing) into a
// queue; a negedge monitor pops one record for every cpuEn pulse it observes.
// ---------------------------------------------------------------------------
module tb_sm_clk_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  devide;
    logic        stepBtn;
    logic [7:0]  burstLen;
    logic        cpuEn;
    logic        busy;
    logic [2:0]  state;
    logic [31:0] stepCnt;

    sm_clk_ctrl #(
        .SHIFT      (0),
        .DIV_W      (16),
        .DEB_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .devide   (devide),
        .stepBtn  (stepBtn),
        .burstLen (burstLen),
        .cpuEn    (cpuEn),
        .busy     (busy),
        .state    (state),
        .stepCnt  (stepCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] cnt;
        int          gap;   // cycles since previous pulse / reset release, 0 = unchecked
    } exp_t;

    exp_t expQ[$];
    exp_t expItem;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   lastCyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && cpuEn) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: cyc=%0d state=%0d stepCnt=%0d, required no pulse",
                         cyc, state, stepCnt);
            end else begin
                expItem = expQ.pop_front();
                if (state !== expItem.st || stepCnt !== expItem.cnt ||
                    (expItem.gap != 0 && (cyc - lastCyc) != expItem.gap)) begin
                    miscompares++;
                    $display("FAIL pulse: state=%0d stepCnt=%0d gap=%0d, required state=%0d stepCnt=%0d gap=%0d",
                             state, stepCnt, cyc - lastCyc, expItem.st, expItem.cnt, expItem.gap);
                end else begin
                    $display("pulse ok: cyc=%0d state=%0d stepCnt=%0d gap=%0d",
                             cyc, state, stepCnt, cyc - lastCyc);
                end
            end
            lastCyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("check ok %s: 0x%0h", name, act);
        end
    endtask

    task automatic pushExp(input logic [2:0] st, input logic [31:0] cnt, input int gap);
        exp_t item;
        item.st  = st;
        item.cnt = cnt;
        item.gap = gap;
        expQ.push_back(item);
    endtask

    task automatic checkDrained(input string name);
        check(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset(input logic [1:0] m, input logic [3:0] dv, input logic [7:0] bl);
        @(negedge clk);
        rst      = 1'b1;
        mode     = m;
        devide   = dv;
        burstLen = bl;
        stepBtn  = 1'b0;
        waitCycles(3);
        check("reset_cpuEn",   32'(cpuEn),  32'd0);
        check("reset_state",   32'(state),  32'd0);
        check("reset_stepCnt", stepCnt,     32'd0);
        rst     = 1'b0;
        lastCyc = cyc;
    endtask

    task automatic press(input int holdCycles, input int releaseCycles);
        stepBtn = 1'b1;
        waitCycles(holdCycles);
        stepBtn = 1'b0;
        waitCycles(releaseCycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        rst      = 1'b1;
        mode     = 2'b00;
        devide   = 4'd0;
        stepBtn  = 1'b0;
        burstLen = 8'd0;

        // 1. Reset held in RUN, then RUN at period 4: pulses 4 cycles after entry.
        doReset(2'b01, 4'd2, 8'd0);
        check("reset_busy", 32'(busy), 32'd0);
        pushExp(3'd1, 32'd1, 5);
        for (int i = 2; i <= 5; i++) pushExp(3'd1, 32'(i), 4);
        waitCycles(21);
        check("run_stepCnt_20", stepCnt, 32'd5);
        check("run_busy", 32'(busy), 32'd1);
        mode = 2'b00;
        waitCycles(3);
        check("halt_state", 32'(state), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);
        checkDrained("run_pending");

        // 2. Single step with debounce.
        doReset(2'b10, 4'd0, 8'd0);
        waitCycles(2);
        check("step_state", 32'(state), 32'd2);
        press(3, 10);                       // 3-cycle glitch is rejected
        check("glitch_stepCnt", stepCnt, 32'd0);
        pushExp(3'd2, 32'd1, 0);
        press(10, 10);
        check("step1_stepCnt", stepCnt, 32'd1);
        pushExp(3'd2, 32'd2, 0);
        press(10, 10);
        check("step2_stepCnt", stepCnt, 32'd2);
        checkDrained("step_pending");

        // 3. Burst of 3 at period 2; last pulse coincides with return to ARMED.
        doReset(2'b11, 4'd1, 8'd3);
        waitCycles(2);
        check("armed_state", 32'(state), 32'd3);
        check("armed_busy", 32'(busy), 32'd0);
        pushExp(3'd4, 32'd1, 0);
        pushExp(3'd4, 32'd2, 2);
        pushExp(3'd3, 32'd3, 2);
        stepBtn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd4) found = 1'b1;
        end
        check("burst_entered", 32'(found), 32'd1);
        check("burst_busy", 32'(busy), 32'd1);
        waitCycles(3);
        stepBtn = 1'b0;
        waitCycles(12);
        check("burst_done_state", 32'(state), 32'd3);
        check("burst_done_busy", 32'(busy), 32'd0);
        check("burst_stepCnt", stepCnt, 32'd3);
        checkDrained("burst_pending");
        burstLen = 8'd0;
        press(10, 10);
        check("burst0_state", 32'(state), 32'd3);
        check("burst0_stepCnt", stepCnt, 32'd3);

        // 4. Abort mid-burst after the first pulse.
        doReset(2'b11, 4'd1, 8'd3);
        waitCycles(2);
        pushExp(3'd4, 32'd1, 0);
        stepBtn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (cpuEn) found = 1'b1;
        end
        check("abort_first_pulse", 32'(found), 32'd1);
        mode = 2'b00;
        waitCycles(5);
        stepBtn = 1'b0;
        waitCycles(15);
        check("abort_state", 32'(state), 32'd0);
        check("abort_stepCnt", stepCnt, 32'd1);
        mode = 2'b11;
        waitCycles(10);
        check("rearm_state", 32'(state), 32'd3);
        check("rearm_stepCnt", stepCnt, 32'd1);
        checkDrained("abort_pending");

        // 5. Rate change 3 -> 0 mid-period in RUN.
        doReset(2'b01, 4'd3, 8'd0);
        pushExp(3'd1, 32'd1, 9);
        pushExp(3'd1, 32'd2, 6);            // clear cycle emits nothing
        for (int i = 3; i <= 6; i++) pushExp(3'd1, 32'(i), 1);
        waitCycles(13);
        devide = 4'd0;
        waitCycles(6);
        mode = 2'b00;
        waitCycles(3);
        check("devchg_stepCnt", stepCnt, 32'd6);
        check("devchg_state", 32'(state), 32'd0);
        checkDrained("devchg_pending");

        // 6. stepCnt wrap.
        doReset(2'b10, 4'd0, 8'd0);
        waitCycles(2);
        force dut.stepCntReg = 32'hFFFF_FFFF;
        #1;
        release dut.stepCntReg;
        @(negedge clk);
        check("wrap_preload", stepCnt, 32'hFFFF_FFFF);
        pushExp(3'd2, 32'd0, 0);
        press(10, 10);
        check("wrap_stepCnt", stepCnt, 32'd0);
        checkDrained("wrap_pending");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm_clk_ctrl.md
Name: sm_clk_ctrl

Overview:
Run-control sequencer for the schoolMIPS core clock. It generates a single-cycle clock-enable pulse, cpuEn, for the core, driven from the board clock. Four modes are supported: halt, free-run at a programmable divided rate, single-step from a debounced button, and a burst of N steps per button press. It replaces free-running counter division as the source of core advance and sits between the board switches/button and the core's enable input.

Parameters:
SHIFT, 16, base prescaler exponent; run period = 2^(SHIFT+devide) clk cycles
DIV_W, 32, prescaler counter width; must satisfy DIV_W >= SHIFT+16
DEB_CYCLES, 1000, consecutive stable cycles required to accept a new button level (>=1)

Ports:
clk  in  1  board clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
mode  in  2  00 halt, 01 run, 10 single-step, 11 burst; already synchronised by caller
devide  in  4  rate select for run/burst
stepBtn  in  1  raw asynchronous button
burstLen  in  8  steps per burst; 0 = burst disabled
cpuEn  out  1  one-cycle core advance pulse
busy  out  1  high in RUN or BURST
state  out  3  encoded FSM state
stepCnt  out  32  total cpuEn pulses issued since reset

Behaviour:
- Reset (async, rst=1): state=HALT, cpuEn=0, busy=0, stepCnt=0, prescaler=0, burst remaining=0, sync flops=0, debounced level=0, debounce counter=0.
- Button path: 2-flop synchroniser, then debouncer. The debounce counter increments while the synced level differs from the debounced level and clears when they are equal. When the count reaches DEB_CYCLES, the debounced level flips and the counter clears. A rise is a one-cycle pulse on the 0->1 debounced transition.
- Prescaler: counts 0..2^(SHIFT+devide)-1 while in RUN or BURST; otherwise held at 0. Terminal count (tc) = prescaler at maximum; on tc it wraps to 0. A change of devide (compared against a registered copy) clears the prescaler that cycle and suppresses tc.
- State encodings: HALT=0, RUN=1, STEP=2, ARMED=3, BURST=4.
- Mode decode, highest priority, evaluated every cycle:
  - 00 -> HALT.
  - 01 -> RUN.
  - 10 -> STEP.
  - 11 -> ARMED if not currently ARMED/BURST.
  - On any mode change the prescaler clears and no cpuEn is issued that cycle.
- HALT: cpuEn=0.
- RUN: cpuEn=1 on each tc. The first pulse comes 2^(SHIFT+devide) cycles after entry.
- STEP: each rise yields exactly one cpuEn, registered one cycle after the rise pulse.
- ARMED: a rise with burstLen!=0 loads remaining=burstLen and moves to BURST. A rise with burstLen=0 is ignored.
- BURST: cpuEn=1 on tc and remaining decrements. When the pulse with remaining=1 fires, go to ARMED. Rises during BURST are ignored. burstLen is sampled only at load.
- cpuEn is a registered output: at most one pulse per cycle, never two consecutive cycles except in RUN/BURST with SHIFT+devide=0.
- stepCnt increments on every cycle cpuEn=1 and wraps 0xFFFFFFFF->0.
- busy = (state==RUN)||(state==BURST).
- Reset asserted mid-burst: immediate return to reset values; no partial pulse after release.

Test Plan:
All scenarios use SHIFT=0, DEB_CYCLES=4.
1. Reset: rst high with mode=01 -> cpuEn=0, state=0, stepCnt=0. After release, in RUN with devide=2, cpuEn pulses every 4 cycles; stepCnt=5 after 20 cycles in RUN.
2. Step debounce: mode=10. Button glitch high for 3 cycles -> no cpuEn. Button held high for 10 cycles -> exactly one cpuEn and stepCnt=1. Release, then press again -> stepCnt=2.
3. Burst: mode=11, burstLen=3, devide=1, one clean press -> 3 cpuEn pulses spaced 2 cycles apart, state 3->4->3, busy high only during BURST. With burstLen=0, a press -> no pulses.
4. Abort: mode switched 11->00 mid-burst after the 1st pulse -> no further cpuEn, state=0. Returning to 11 -> ARMED with no pulse until the next press.
5. devide change in RUN: devide 3->0 at mid-count -> the prescaler clears, no pulse that cycle, then pulses every cycle.
6. Wrap: force stepCnt to 0xFFFFFFFF (backdoor), then one step -> stepCnt=0.
